// File: rtl/param_icache_ctrl.sv
// Parametrised read-only set-associative instruction cache with integrated miss FSM,
// per-set victim pointers and single-cycle flush. Define ICACHE_STATS_EN for hit/miss counters.
module param_icache_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int BO_W  = $clog2(DATA_W / 8);
  localparam int WO_W  = $clog2(WORDS);
  localparam int IX_W  = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IX_W - WO_W - BO_W;
  localparam int WC_W  = (WORDS > 1) ? WO_W : 1;
  localparam int IXB_W = (SETS > 1) ? IX_W : 1;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_FILL, S_REPLY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [WC_W-1:0]   cnt_q;
  logic              pend_q;

  logic              valid_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];
  logic [WAY_W-1:0]  vic_q   [SETS];

  logic [TAG_W-1:0] tag;
  logic [IXB_W-1:0] idx;
  logic [WC_W-1:0]  woff;

  assign tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign idx  = (SETS > 1)  ? addr_q[BO_W+WO_W +: IXB_W] : '0;
  assign woff = (WORDS > 1) ? addr_q[BO_W +: WC_W] : '0;

  function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
    if (WAYS == 1) return '0;
    return (int'(w) == WAYS - 1) ? '0 : w + WAY_W'(1);
  endfunction

  // Tag match and victim choice for the registered address.
  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way;
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  logic load_addr, do_flush, hit_upd, miss_set, fill_we, fill_last;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    way_d     = way_q;
    cpu_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    load_addr = 1'b0;
    do_flush  = 1'b0;
    hit_upd   = 1'b0;
    miss_set  = 1'b0;
    fill_we   = 1'b0;
    fill_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush || pend_q) begin
          do_flush = 1'b1;
        end else begin
          cpu_ready = 1'b1;
          if (cpu_req) begin
            load_addr = 1'b1;
            state_d   = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          rsp_valid = 1'b1;
          rsp_data  = data_q[idx][hit_way][woff];
          hit_upd   = 1'b1;
          state_d   = S_IDLE;
        end else begin
          miss_set = 1'b1;
          way_d    = inv_found ? inv_way : vic_q[idx];
          state_d  = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx, {(WO_W+BO_W){1'b0}}};
        if (mem_ack) state_d = S_FILL;
      end
      S_FILL: begin
        if (mem_valid) begin
          fill_we = 1'b1;
          if (cnt_q == WC_W'(WORDS - 1)) begin
            fill_last = 1'b1;
            state_d   = S_REPLY;
          end
        end
      end
      S_REPLY: begin
        rsp_valid = 1'b1;
        rsp_data  = data_q[idx][way_q][woff];
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      if (load_addr) addr_q <= cpu_addr;
      if (miss_set)     cnt_q <= '0;
      else if (fill_we) cnt_q <= cnt_q + WC_W'(1);
      // A flush outside IDLE waits until the current access has responded.
      if (flush && state_q != S_IDLE) pend_q <= 1'b1;
      else if (do_flush)              pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        vic_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (do_flush) begin
      for (int s = 0; s < SETS; s++) begin
        vic_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else begin
      if (hit_upd) vic_q[idx] <= next_way(hit_way);
      if (fill_last) begin
        valid_q[idx][way_q] <= 1'b1;
        vic_q[idx]          <= next_way(way_q);
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (fill_we)   data_q[idx][way_q][cnt_q] <= mem_data;
    if (fill_last) tag_q[idx][way_q]         <= tag;
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (do_flush) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_upd && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (miss_set && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_param_icache_ctrl.sv
// Self-checking bench for param_icache_ctrl (default geometry): directed table, corner
// sequences and randomized fetches against a tag-level cache model and a memory image.
module tb_param_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, cpu_req, mem_ack, mem_valid;
  logic [15:0] cpu_addr, mem_data;
  logic        cpu_ready, rsp_valid, mem_req;
  logic [15:0] rsp_data, mem_addr;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  param_icache_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Memory image: block 0x123x holds 0xA000+offset, everything else a hash of the word address.
  function automatic logic [15:0] img(input logic [15:0] a);
    logic [15:0] wa;
    wa = {1'b0, a[15:1]};
    if (a[15:4] == 12'h123) return 16'hA000 | {13'd0, a[3:1]};
    return (wa * 16'h03C5) ^ 16'h5A5A;
  endfunction

  // Cache model: 64 sets x 2 ways of tags plus a round-robin victim pointer per set.
  bit       m_val [64][2];
  bit [5:0] m_tag [64][2];
  int       m_ptr [64];

  task automatic m_clear();
    for (int s = 0; s < 64; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 2; w++) m_val[s][w] = 1'b0;
    end
  endtask

  task automatic m_access(input logic [15:0] a, output bit h);
    int s, hw, v;
    s = int'(a[9:4]); h = 1'b0; hw = 0; v = -1;
    for (int w = 1; w >= 0; w--)
      if (m_val[s][w] && m_tag[s][w] == a[15:10]) begin h = 1'b1; hw = w; end
    if (h) begin
      m_ptr[s] = (hw + 1) % 2;
    end else begin
      for (int w = 1; w >= 0; w--) if (!m_val[s][w]) v = w;
      if (v < 0) v = m_ptr[s];
      m_val[s][v] = 1'b1;
      m_tag[s][v] = a[15:10];
      m_ptr[s]    = (v + 1) % 2;
    end
  endtask

  // Issues one fetch and plays the memory side. lat counts cycles after the accept edge.
  task automatic fetch(input logic [15:0] a, input int gap, input int dly, input int flush_at,
                       input int abort_at, output bit hit, output logic [15:0] data,
                       output int lat, output int last_lat);
    bit done, acked, gt, seen_req;
    int words, d, w;
    done = 0; acked = 0; gt = 0; seen_req = 0; words = 0; d = dly;
    hit = 1'b1; data = '0; lat = 0; last_lat = 0;
    w = 0;
    while (!cpu_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!cpu_ready) check("ready_timeout", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1; cpu_addr = a;
    @(posedge clk); #1;
    cpu_req = 1'b0; lat = 1;
    for (int c = 0; c < 200; c++) begin
      mem_ack = 1'b0; mem_valid = 1'b0; flush = 1'b0;
      if (abort_at > 0 && words == abort_at) begin done = 1; break; end
      if (rsp_valid) begin data = rsp_data; done = 1; break; end
      if (mem_req) begin
        hit = 1'b0;
        if (!seen_req) check("mem_addr", 32'(mem_addr), 32'({a[15:4], 4'h0}));
        seen_req = 1;
        if (d == 0) begin mem_ack = 1'b1; acked = 1; end
        else d--;
      end else if (acked && words < 8) begin
        gt = ~gt;
        if (gap == 0 || gt) begin
          mem_valid = 1'b1;
          mem_data  = img({a[15:4], 4'h0} + 16'(words * 2));
          words++;
          if (words == 8) last_lat = lat;
          if (flush_at > 0 && words == flush_at) flush = 1'b1;
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    mem_ack = 1'b0; mem_valid = 1'b0; flush = 1'b0;
    if (!done) check("fetch_timeout", 32'd0, 32'd1);
  endtask

  task automatic flush_idle();
    int w;
    w = 0;
    while (!cpu_ready && w < 20) begin @(posedge clk); #1; w++; end
    flush = 1'b1; #1;
    check("ready_during_flush", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    m_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, "_mem_req"},   32'(mem_req),   32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
  endtask

  typedef struct {
    logic [15:0] addr;
    int          dly;
    bit          exp_hit;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit          h, mh;
    logic [15:0] d, a;
    int          lat, last;

    vecs[0] = '{16'h1234, 0, 1'b0, 16'hA002};
    vecs[1] = '{16'h1236, 0, 1'b1, 16'hA003};
    vecs[2] = '{16'h5230, 1, 1'b0, img(16'h5230)};
    vecs[3] = '{16'h5230, 0, 1'b1, img(16'h5230)};
    vecs[4] = '{16'h1230, 0, 1'b1, 16'hA000};
    vecs[5] = '{16'h9230, 2, 1'b0, img(16'h9230)};
    vecs[6] = '{16'h1230, 0, 1'b1, 16'hA000};
    vecs[7] = '{16'h523C, 0, 1'b0, img(16'h523C)};
    vecs[8] = '{16'h123E, 0, 1'b1, 16'hA007};
    vecs[9] = '{16'h9232, 0, 1'b0, img(16'h9232)};

    rst = 1'b0; flush = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
    mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cold-miss / hit / replacement table.
    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].addr, 0, vecs[i].dly, 0, 0, h, d, lat, last);
      m_access(vecs[i].addr, mh);
      check($sformatf("vec%0d_hit", i), 32'(h), 32'(vecs[i].exp_hit));
      check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_lat", i), 32'(lat),
            vecs[i].exp_hit ? 32'd1 : 32'(11 + vecs[i].dly));
    end

    // Fill with alternating mem_valid gaps; reply exactly one cycle after the last word.
    fetch(16'h2468, 1, 2, 0, 0, h, d, lat, last);
    m_access(16'h2468, mh);
    check("gap_hit", 32'(h), 32'd0);
    check("gap_data", 32'(d), 32'(img(16'h2468)));
    check("gap_reply_lat", 32'(lat), 32'(last + 1));
    fetch(16'h246E, 0, 0, 0, 0, h, d, lat, last);
    m_access(16'h246E, mh);
    check("gap_block_hit", 32'(h), 32'd1);
    check("gap_block_data", 32'(d), 32'(img(16'h246E)));

    // Flush in IDLE, then a previously cached address misses.
    flush_idle();
    fetch(16'h1234, 0, 0, 0, 0, h, d, lat, last);
    m_access(16'h1234, mh);
    check("flush_idle_miss", 32'(h), 32'd0);
    check("flush_idle_data", 32'(d), 32'hA002);

    // Flush during FILL: reply still delivered, then everything invalid.
    fetch(16'h7774, 0, 0, 4, 0, h, d, lat, last);
    check("flush_fill_data", 32'(d), 32'(img(16'h7774)));
    m_clear();
    fetch(16'h7774, 0, 0, 0, 0, h, d, lat, last);
    m_access(16'h7774, mh);
    check("flush_fill_refetch_miss", 32'(h), 32'd0);
    fetch(16'h1234, 0, 0, 0, 0, h, d, lat, last);
    m_access(16'h1234, mh);
    check("flush_fill_other_miss", 32'(h), 32'd0);

    // Reset in the middle of a fill.
    fetch(16'h3456, 0, 0, 0, 3, h, d, lat, last);
    rst = 1'b0; #1;
    check_reset_outputs("midfill");
    @(posedge clk); #1;
    rst = 1'b1;
    m_clear();
    @(posedge clk); #1;
    fetch(16'h3456, 0, 0, 0, 0, h, d, lat, last);
    m_access(16'h3456, mh);
    check("midfill_refetch_miss", 32'(h), 32'd0);
    check("midfill_refetch_data", 32'(d), 32'(img(16'h3456)));
    fetch(16'h3450, 0, 0, 0, 0, h, d, lat, last);
    m_access(16'h3450, mh);
    fetch(16'h345E, 0, 0, 0, 0, h, d, lat, last);
    m_access(16'h345E, mh);
    check("after_reset_hit", 32'(h), 32'd1);
`ifdef ICACHE_STATS_EN
    check("stats_hit_cnt", 32'(hit_cnt), 32'd2);
    check("stats_miss_cnt", 32'(miss_cnt), 32'd1);
`endif
    flush_idle();
`ifdef ICACHE_STATS_EN
    check("stats_hit_clr", 32'(hit_cnt), 32'd0);
    check("stats_miss_clr", 32'(miss_cnt), 32'd0);
`endif

    // Randomized fetches over a few contended sets.
    for (int i = 0; i < 150; i++) begin
      int gap, dly;
      if ($urandom_range(0, 14) == 0) flush_idle();
      a = {6'($urandom_range(0, 3) * 5 + 1), 6'($urandom_range(0, 1) + 12),
           3'($urandom_range(0, 7)), 1'b0};
      gap = int'($urandom_range(0, 1));
      dly = int'($urandom_range(0, 2));
      fetch(a, gap, dly, 0, 0, h, d, lat, last);
      m_access(a, mh);
      check($sformatf("rnd%0d_hit", i), 32'(h), 32'(mh));
      check($sformatf("rnd%0d_data", i), 32'(d), 32'(img(a)));
      if (mh) check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd1);
      else if (gap == 0) check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(11 + dly));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
